// File: rtl/mini_src_pkg.sv
// Shared types for the mini SRC control unit: strobe bundle, FSM states,
// opcode/ALU encodings and the opcode-to-class decoder.
package mini_src_pkg;

    typedef struct packed {
        logic       PCout;
        logic       PCin;
        logic       IncPC;
        logic       MARin;
        logic       MDRin;
        logic       MDRout;
        logic       Read;
        logic       MemRead;
        logic       MemWrite;
        logic       IRin;
        logic       Yin;
        logic       Zhighin;
        logic       Zlowin;
        logic       Zlowout;
        logic       Gra;
        logic       Grb;
        logic       Grc;
        logic       Rin;
        logic       Rout;
        logic       BAout;
        logic       Cout;
        logic       CONin;
        logic       InPortout;
        logic       OutPortin;
        logic [4:0] alu_op;
    } ctl_t;

    typedef enum logic [3:0] {
        S_RST, S_FETCH0, S_FETCH1, S_FETCH2, S_DECODE,
        S_E3, S_E4, S_E5, S_E6, S_E7, S_HALT
    } state_t;

    typedef enum logic [3:0] {
        C_ILL, C_ALUR, C_ALUI, C_LD, C_ST, C_BR, C_OUT, C_IN, C_HALT
    } opc_class_t;

    localparam logic [4:0] OPC_LD   = 5'b00000;
    localparam logic [4:0] OPC_ST   = 5'b00010;
    localparam logic [4:0] OPC_ADD  = 5'b00011;
    localparam logic [4:0] OPC_SUB  = 5'b00100;
    localparam logic [4:0] OPC_AND  = 5'b00101;
    localparam logic [4:0] OPC_OR   = 5'b00110;
    localparam logic [4:0] OPC_ADDI = 5'b01100;
    localparam logic [4:0] OPC_ANDI = 5'b01101;
    localparam logic [4:0] OPC_ORI  = 5'b01110;
    localparam logic [4:0] OPC_BR   = 5'b10010;
    localparam logic [4:0] OPC_IN   = 5'b10110;
    localparam logic [4:0] OPC_OUT  = 5'b10111;
    localparam logic [4:0] OPC_HALT = 5'b11011;

    // ALU operation codes reuse the opcode values
    localparam logic [4:0] ALU_ADD  = OPC_ADD;

    function automatic opc_class_t opc_class(input logic [4:0] opc);
        opc_class_t cls;
        case (opc)
            OPC_ADD, OPC_SUB, OPC_AND, OPC_OR: cls = C_ALUR;
            OPC_ADDI, OPC_ANDI, OPC_ORI:       cls = C_ALUI;
            OPC_LD:                            cls = C_LD;
            OPC_ST:                            cls = C_ST;
            OPC_BR:                            cls = C_BR;
            OPC_OUT:                           cls = C_OUT;
            OPC_IN:                            cls = C_IN;
            OPC_HALT:                          cls = C_HALT;
            default:                           cls = C_ILL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/mini_src_wait_ctr.sv
// Memory wait counter: loads MEM_WAIT on entry to a read state, counts
// down to zero and saturates there so it can never wrap.
module mini_src_wait_ctr #(
    parameter int unsigned MEM_WAIT = 1
) (
    input  logic i_clk,
    input  logic i_clr,
    input  logic i_load,
    input  logic i_dec,
    output logic o_done
);

    localparam logic [2:0] LOAD_VAL = 3'(MEM_WAIT);

    logic [2:0] r_cnt;

    // Remaining wait cycles of the current read state
    always_ff @(posedge i_clk or negedge i_clr) begin
        if (!i_clr) begin
            r_cnt <= 3'd0;
        end else if (i_load) begin
            r_cnt <= LOAD_VAL;
        end else if (i_dec && (r_cnt != 3'd0)) begin
            r_cnt <= r_cnt - 3'd1;
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_done = (r_cnt == 3'd0);

endmodule

// File: rtl/mini_src_control_unit.sv
// Hardwired control FSM for the mini SRC: fetch, decode and per-class
// execute sequences, with strobes registered one cycle behind the state.
module mini_src_control_unit
    import mini_src_pkg::*;
#(
    parameter int unsigned MEM_WAIT = 1
) (
    input  logic        i_clk,
    input  logic        i_clr,
    input  logic [31:0] i_ir,
    input  logic        i_con_ff,
    input  logic        i_stop,
    output logic        o_run,
    output ctl_t        o_ctl
);

    state_t     r_state;
    state_t     w_next;
    logic [4:0] r_opc;
    opc_class_t w_cls;
    opc_class_t w_dec_cls;
    logic       w_wait_load;
    logic       w_wait_dec;
    logic       w_wait_done;
    ctl_t       w_ctl;
    ctl_t       r_ctl;
    logic       r_run;
    logic       w_unused_ir;

    assign w_cls       = opc_class(r_opc);
    assign w_dec_cls   = opc_class(i_ir[31:27]);
    assign w_unused_ir = ^i_ir[26:0];

    mini_src_wait_ctr #(.MEM_WAIT(MEM_WAIT)) u_wait (
        .i_clk  (i_clk),
        .i_clr  (i_clr),
        .i_load (w_wait_load),
        .i_dec  (w_wait_dec),
        .o_done (w_wait_done)
    );

    // State register
    always_ff @(posedge i_clk or negedge i_clr) begin
        if (!i_clr) begin
            r_state <= S_RST;
        end else begin
            r_state <= w_next;
        end
    end

    // Opcode latch, captured only in DECODE
    always_ff @(posedge i_clk or negedge i_clr) begin
        if (!i_clr) begin
            r_opc <= 5'd0;
        end else if (r_state == S_DECODE) begin
            r_opc <= i_ir[31:27];
        end else begin
            r_opc <= r_opc;
        end
    end

    // Next-state and wait-counter control
    always_comb begin
        w_next      = r_state;
        w_wait_load = 1'b0;
        w_wait_dec  = 1'b0;
        case (r_state)
            S_RST:    w_next = S_FETCH0;
            S_FETCH0: begin
                if (i_stop) begin
                    w_next = S_HALT;
                end else begin
                    w_next      = S_FETCH1;
                    w_wait_load = 1'b1;
                end
            end
            S_FETCH1: begin
                if (w_wait_done) begin
                    w_next = S_FETCH2;
                end else begin
                    w_wait_dec = 1'b1;
                end
            end
            S_FETCH2: w_next = S_DECODE;
            S_DECODE: begin
                case (w_dec_cls)
                    C_HALT:  w_next = S_HALT;
                    C_ILL:   w_next = S_FETCH0;
                    default: w_next = S_E3;
                endcase
            end
            S_E3: begin
                if ((w_cls == C_OUT) || (w_cls == C_IN)) begin
                    w_next = S_FETCH0;
                end else begin
                    w_next = S_E4;
                end
            end
            S_E4:     w_next = S_E5;
            S_E5: begin
                case (w_cls)
                    C_LD: begin
                        w_next      = S_E6;
                        w_wait_load = 1'b1;
                    end
                    C_ST, C_BR: w_next = S_E6;
                    default:    w_next = S_FETCH0;
                endcase
            end
            S_E6: begin
                case (w_cls)
                    C_LD: begin
                        if (w_wait_done) begin
                            w_next = S_E7;
                        end else begin
                            w_wait_dec = 1'b1;
                        end
                    end
                    C_ST:    w_next = S_E7;
                    default: w_next = S_FETCH0;
                endcase
            end
            S_E7:     w_next = S_FETCH0;
            S_HALT:   w_next = S_HALT;
            default:  w_next = S_RST;
        endcase
    end

    // Strobe decode from the current state and latched opcode class
    always_comb begin
        w_ctl = '0;
        case (r_state)
            S_FETCH0: begin
                w_ctl.PCout = 1'b1; w_ctl.MARin = 1'b1; w_ctl.IncPC = 1'b1;
            end
            S_FETCH1: begin
                w_ctl.MemRead = 1'b1; w_ctl.Read = 1'b1; w_ctl.MDRin = 1'b1;
            end
            S_FETCH2: begin
                w_ctl.MDRout = 1'b1; w_ctl.IRin = 1'b1;
            end
            S_E3: begin
                case (w_cls)
                    C_ALUR, C_ALUI: begin
                        w_ctl.Grb = 1'b1; w_ctl.Rout = 1'b1; w_ctl.Yin = 1'b1;
                    end
                    C_LD, C_ST: begin
                        w_ctl.Grb = 1'b1; w_ctl.BAout = 1'b1; w_ctl.Yin = 1'b1;
                    end
                    C_BR: begin
                        w_ctl.Gra = 1'b1; w_ctl.Rout = 1'b1; w_ctl.CONin = 1'b1;
                    end
                    C_OUT: begin
                        w_ctl.Gra = 1'b1; w_ctl.Rout = 1'b1; w_ctl.OutPortin = 1'b1;
                    end
                    C_IN: begin
                        w_ctl.InPortout = 1'b1; w_ctl.Gra = 1'b1; w_ctl.Rin = 1'b1;
                    end
                    default: w_ctl = '0;
                endcase
            end
            S_E4: begin
                case (w_cls)
                    C_ALUR: begin
                        w_ctl.Grc = 1'b1; w_ctl.Rout = 1'b1;
                        w_ctl.alu_op = r_opc; w_ctl.Zlowin = 1'b1;
                    end
                    C_ALUI: begin
                        w_ctl.Cout = 1'b1; w_ctl.alu_op = r_opc; w_ctl.Zlowin = 1'b1;
                    end
                    C_LD, C_ST: begin
                        w_ctl.Cout = 1'b1; w_ctl.alu_op = ALU_ADD; w_ctl.Zlowin = 1'b1;
                    end
                    C_BR: begin
                        w_ctl.PCout = 1'b1; w_ctl.Yin = 1'b1;
                    end
                    default: w_ctl = '0;
                endcase
            end
            S_E5: begin
                case (w_cls)
                    C_ALUR, C_ALUI: begin
                        w_ctl.Zlowout = 1'b1; w_ctl.Gra = 1'b1; w_ctl.Rin = 1'b1;
                    end
                    C_LD, C_ST: begin
                        w_ctl.Zlowout = 1'b1; w_ctl.MARin = 1'b1;
                    end
                    C_BR: begin
                        w_ctl.Cout = 1'b1; w_ctl.alu_op = ALU_ADD; w_ctl.Zlowin = 1'b1;
                    end
                    default: w_ctl = '0;
                endcase
            end
            S_E6: begin
                case (w_cls)
                    C_LD: begin
                        w_ctl.MemRead = 1'b1; w_ctl.Read = 1'b1; w_ctl.MDRin = 1'b1;
                    end
                    C_ST: begin
                        w_ctl.Gra = 1'b1; w_ctl.Rout = 1'b1; w_ctl.MDRin = 1'b1;
                    end
                    C_BR: begin
                        w_ctl.Zlowout = 1'b1; w_ctl.PCin = i_con_ff;
                    end
                    default: w_ctl = '0;
                endcase
            end
            S_E7: begin
                case (w_cls)
                    C_LD: begin
                        w_ctl.MDRout = 1'b1; w_ctl.Gra = 1'b1; w_ctl.Rin = 1'b1;
                    end
                    C_ST:    w_ctl.MemWrite = 1'b1;
                    default: w_ctl = '0;
                endcase
            end
            default: w_ctl = '0;
        endcase
    end

    // Registered Moore outputs
    always_ff @(posedge i_clk or negedge i_clr) begin
        if (!i_clr) begin
            r_ctl <= '0;
            r_run <= 1'b0;
        end else begin
            r_ctl <= w_ctl;
            r_run <= (r_state != S_HALT) && (r_state != S_RST);
        end
    end

    assign o_ctl = r_ctl;
    assign o_run = r_run;

endmodule

// File: tb/tb_mini_src_control_unit.sv
// Scoreboard bench: three control units (MEM_WAIT 0,1,2) driven in turn;
// expected strobe words come from an instruction-level sequence table.
module tb_mini_src_control_unit;
    import mini_src_pkg::*;

    localparam int NU = 3;

    typedef struct {
        bit   run;
        ctl_t c;
    } word_t;

    typedef struct {
        int     u;
        longint due;
        bit     run;
        ctl_t   c;
    } exp_t;

    logic        clk;
    logic        clr  [NU];
    logic [31:0] ir   [NU];
    logic        con  [NU];
    logic        stop [NU];
    logic        run  [NU];
    ctl_t        ctl  [NU];

    int     total = 0;
    int     bad   = 0;
    longint cyc   = 0;
    exp_t   sbq[$];
    word_t  plan[$];
    logic [4:0] rnd_ops [0:13];

    for (genvar g = 0; g < NU; g++) begin : g_dut
        mini_src_control_unit #(.MEM_WAIT(g)) u_dut (
            .i_clk    (clk),
            .i_clr    (clr[g]),
            .i_ir     (ir[g]),
            .i_con_ff (con[g]),
            .i_stop   (stop[g]),
            .o_run    (run[g]),
            .o_ctl    (ctl[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: reset-zero checks, then pop and compare due expectations
    always @(negedge clk) begin
        exp_t e;
        logic [28:0] a, r;
        for (int u = 0; u < NU; u++) begin
            if (!clr[u]) begin
                total++;
                a = ctl[u];
                if (a !== 29'd0 || run[u] !== 1'b0) begin
                    bad++;
                    $display("FAIL reset_zero u%0d ctl=%h run=%b required ctl=0 run=0", u, a, run[u]);
                end
            end
        end
        while (sbq.size() > 0 && sbq[0].due < cyc) begin
            e = sbq.pop_front();
            total++; bad++;
            $display("FAIL stale u%0d due=%0d cyc=%0d", e.u, e.due, cyc);
        end
        if (sbq.size() > 0 && sbq[0].due == cyc) begin
            e = sbq.pop_front();
            a = ctl[e.u];
            r = e.c;
            total++;
            if (a !== r || run[e.u] !== e.run) begin
                bad++;
                $display("FAIL seq u%0d cyc=%0d ctl=%h run=%b required ctl=%h run=%b",
                         e.u, cyc, a, run[e.u], r, e.run);
            end
            total++;
            if ((ctl[e.u].MemRead && ctl[e.u].MemWrite) || (ctl[e.u].Rin && ctl[e.u].Rout)) begin
                bad++;
                $display("FAIL excl u%0d cyc=%0d ctl=%h required no MemRead+MemWrite or Rin+Rout", e.u, cyc, a);
            end
        end
    end

    task automatic add(input bit r, input ctl_t c);
        word_t w;
        w.run = r;
        w.c   = c;
        plan.push_back(w);
    endtask

    // Expected strobe words, one per state cycle, for one instruction
    task automatic build(input int mw, input logic [4:0] opc, input bit cf);
        ctl_t c;
        bit alur, alui;
        plan.delete();
        c = '0; c.PCout = 1'b1; c.MARin = 1'b1; c.IncPC = 1'b1; add(1'b1, c);
        c = '0; c.MemRead = 1'b1; c.Read = 1'b1; c.MDRin = 1'b1;
        for (int k = 0; k <= mw; k++) add(1'b1, c);
        c = '0; c.MDRout = 1'b1; c.IRin = 1'b1; add(1'b1, c);
        add(1'b1, '0);
        alur = opc inside {5'b00011, 5'b00100, 5'b00101, 5'b00110};
        alui = opc inside {5'b01100, 5'b01101, 5'b01110};
        if (alur || alui) begin
            c = '0; c.Grb = 1'b1; c.Rout = 1'b1; c.Yin = 1'b1; add(1'b1, c);
            c = '0; c.Zlowin = 1'b1; c.alu_op = opc;
            if (alur) begin c.Grc = 1'b1; c.Rout = 1'b1; end
            else begin c.Cout = 1'b1; end
            add(1'b1, c);
            c = '0; c.Zlowout = 1'b1; c.Gra = 1'b1; c.Rin = 1'b1; add(1'b1, c);
        end else if (opc == 5'b00000 || opc == 5'b00010) begin
            c = '0; c.Grb = 1'b1; c.BAout = 1'b1; c.Yin = 1'b1; add(1'b1, c);
            c = '0; c.Cout = 1'b1; c.alu_op = 5'b00011; c.Zlowin = 1'b1; add(1'b1, c);
            c = '0; c.Zlowout = 1'b1; c.MARin = 1'b1; add(1'b1, c);
            if (opc == 5'b00000) begin
                c = '0; c.MemRead = 1'b1; c.Read = 1'b1; c.MDRin = 1'b1;
                for (int k = 0; k <= mw; k++) add(1'b1, c);
                c = '0; c.MDRout = 1'b1; c.Gra = 1'b1; c.Rin = 1'b1; add(1'b1, c);
            end else begin
                c = '0; c.Gra = 1'b1; c.Rout = 1'b1; c.MDRin = 1'b1; add(1'b1, c);
                c = '0; c.MemWrite = 1'b1; add(1'b1, c);
            end
        end else if (opc == 5'b10010) begin
            c = '0; c.Gra = 1'b1; c.Rout = 1'b1; c.CONin = 1'b1; add(1'b1, c);
            c = '0; c.PCout = 1'b1; c.Yin = 1'b1; add(1'b1, c);
            c = '0; c.Cout = 1'b1; c.alu_op = 5'b00011; c.Zlowin = 1'b1; add(1'b1, c);
            c = '0; c.Zlowout = 1'b1; c.PCin = cf; add(1'b1, c);
        end else if (opc == 5'b10111) begin
            c = '0; c.Gra = 1'b1; c.Rout = 1'b1; c.OutPortin = 1'b1; add(1'b1, c);
        end else if (opc == 5'b10110) begin
            c = '0; c.InPortout = 1'b1; c.Gra = 1'b1; c.Rin = 1'b1; add(1'b1, c);
        end else if (opc == 5'b11011) begin
            for (int k = 0; k < 20; k++) add(1'b0, '0);
        end
    endtask

    // One state cycle: the registered response appears one cycle later
    task automatic step(input int u, input bit r, input ctl_t c);
        exp_t e;
        e.u = u; e.due = cyc + 1; e.run = r; e.c = c;
        sbq.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic do_reset(input int u);
        clr[u]  = 1'b0;
        stop[u] = 1'b0;
        sbq.delete();
        repeat (3) begin @(posedge clk); #1; end
        clr[u] = 1'b1;
        step(u, 1'b0, '0);
    endtask

    task automatic run_instr(input int u, input logic [31:0] irv, input bit cf, input int abort_at);
        build(u, irv[31:27], cf);
        ir[u]  = irv;
        con[u] = cf;
        for (int i = 0; i <= plan.size(); i++) begin
            if (i == abort_at) begin
                do_reset(u);
                return;
            end
            if (i < plan.size()) step(u, plan[i].run, plan[i].c);
        end
    endtask

    task automatic stop_test(input int u);
        ctl_t c;
        c = '0; c.PCout = 1'b1; c.MARin = 1'b1; c.IncPC = 1'b1;
        stop[u] = 1'b1;
        step(u, 1'b1, c);
        stop[u] = 1'b0;
        repeat (20) step(u, 1'b0, '0);
        do_reset(u);
    endtask

    initial begin
        logic [4:0] opc;
        int ab;
        rnd_ops = '{5'b00000, 5'b00010, 5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b01100,
                    5'b01101, 5'b01110, 5'b10010, 5'b10110, 5'b10111, 5'b11111, 5'b00001};
        for (int u = 0; u < NU; u++) begin
            clr[u] = 1'b0; ir[u] = 32'd0; con[u] = 1'b0; stop[u] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int u = 0; u < NU; u++) begin
            do_reset(u);
            run_instr(u, 32'h18918000, 1'b0, -1);
            run_instr(u, {5'b00010, 27'h0123456}, 1'b0, -1);
            run_instr(u, {5'b10010, 27'h0000001}, 1'b0, -1);
            run_instr(u, {5'b10010, 27'h0000002}, 1'b1, -1);
            run_instr(u, {5'b00000, 27'h0042000}, 1'b0, -1);
            run_instr(u, {5'b11111, 27'h0000000}, 1'b0, -1);
            run_instr(u, {5'b01100, 27'h0000055}, 1'b0, -1);
            run_instr(u, {5'b10111, 27'h0000000}, 1'b0, -1);
            run_instr(u, {5'b10110, 27'h0000000}, 1'b0, -1);
            stop_test(u);
            run_instr(u, {5'b11011, 27'h0000000}, 1'b0, -1);
            do_reset(u);
            // reset lands while MemWrite is on the output
            run_instr(u, {5'b00010, 27'h0000777}, 1'b0, u + 9);
            for (int n = 0; n < 30; n++) begin
                opc = rnd_ops[$urandom_range(13, 0)];
                ab  = ($urandom_range(7, 0) == 0) ? int'($urandom_range(12, 1)) : -1;
                run_instr(u, {opc, 27'($urandom)}, 1'($urandom), ab);
            end
            @(negedge clk); #1;
            total++;
            if (sbq.size() != 0) begin
                bad++;
                $display("FAIL drain u%0d pending=%0d required 0", u, sbq.size());
                sbq.delete();
            end
            clr[u] = 1'b0;
            @(posedge clk); #1;
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
